// File: rtl/dpll_shift_scheduler.sv
// DPLL loop filter and shift scheduler: random-walk filter on lead/lag strobes,
// rate-limited single-cycle shift commands, divider initial-value owner, lock detect.
module dpll_shift_scheduler #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned FILT_W   = 4,
   parameter int unsigned HOLD_W   = 4,
   parameter int unsigned LOCK_W   = 8,
   parameter int unsigned INIT_DIV = 50
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              lead_i,
   input  logic              lag_i,
   input  logic [FILT_W-1:0] filt_len_i,
   input  logic [HOLD_W-1:0] holdoff_i,
   input  logic [WIDTH-1:0]  div_ratio_i,
   input  logic              load_i,
   output logic              positiveShift_o,
   output logic              negativeShift_o,
   output logic [WIDTH-1:0]  initValue_o,
   output logic              locked_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILTER  = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_nxt;
   logic signed [FILT_W:0] r_acc;
   logic signed [FILT_W:0] w_lim;
   logic                  r_dir;
   logic [HOLD_W-1:0]     r_hold;
   logic [LOCK_W-1:0]     r_lock;
   logic [LOCK_W-1:0]     w_lock_inc;
   logic                  r_pend;
   logic [WIDTH-1:0]      r_pend_val;
   logic [WIDTH-1:0]      r_init;
   logic                  r_pos;
   logic                  r_neg;
   logic                  r_locked;
   logic                  r_busy;
   logic                  w_lead;
   logic                  w_lag;
   logic                  w_hit_pos;
   logic                  w_hit_neg;
   logic                  w_defer;

   // threshold magnitude N-1, with N=0 behaving as N=1
   assign w_lim      = (filt_len_i == '0) ? '0 : $signed({1'b0, filt_len_i} - 1'b1);
   assign w_lead     = lead_i & ~lag_i;
   assign w_lag      = lag_i & ~lead_i;
   assign w_hit_pos  = w_lead && (r_acc == w_lim);
   assign w_hit_neg  = w_lag && (r_acc == -w_lim);
   assign w_lock_inc = (r_lock == '1) ? r_lock : r_lock + 1'b1;

   always_comb begin
      w_nxt = r_state;
      if (!enable_i) begin
         w_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_nxt = ST_FILTER;
            ST_FILTER:  if (w_hit_pos || w_hit_neg) w_nxt = ST_SHIFT;
            ST_SHIFT:   w_nxt = (holdoff_i != '0) ? ST_HOLDOFF : ST_FILTER;
            ST_HOLDOFF: if (r_hold <= HOLD_W'(1)) w_nxt = ST_FILTER;
            default:    w_nxt = ST_IDLE;
         endcase
      end
   end

   // a load is deferred only while staying inside SHIFT/HOLDOFF; the edge that
   // leaves them commits the pending value
   assign w_defer = ((r_state == ST_SHIFT) || (r_state == ST_HOLDOFF)) &&
                    ((w_nxt == ST_SHIFT) || (w_nxt == ST_HOLDOFF));

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state    <= ST_IDLE;
         r_acc      <= '0;
         r_dir      <= 1'b0;
         r_hold     <= '0;
         r_lock     <= '0;
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         r_init     <= WIDTH'(INIT_DIV);
         r_pos      <= 1'b0;
         r_neg      <= 1'b0;
         r_locked   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_busy  <= (w_nxt == ST_SHIFT) || (w_nxt == ST_HOLDOFF);
         r_pos   <= 1'b0;
         r_neg   <= 1'b0;

         if (!enable_i) begin
            r_acc <= '0;
         end else begin
            case (r_state)
               ST_FILTER: begin
                  if (w_hit_pos) begin
                     r_acc <= '0;
                     r_dir <= 1'b1;
                  end else if (w_hit_neg) begin
                     r_acc <= '0;
                     r_dir <= 1'b0;
                  end else if (w_lead) begin
                     r_acc <= r_acc + 1'b1;
                  end else if (w_lag) begin
                     r_acc <= r_acc - 1'b1;
                  end
               end
               ST_SHIFT: begin
                  r_pos  <= r_dir;
                  r_neg  <= ~r_dir;
                  r_hold <= holdoff_i;
                  r_acc  <= '0;
               end
               ST_HOLDOFF: r_hold <= r_hold - 1'b1;
               default:    r_acc  <= '0;
            endcase
         end

         if (w_defer) begin
            if (load_i) begin
               r_pend     <= 1'b1;
               r_pend_val <= div_ratio_i;
            end
         end else if (load_i) begin
            r_init <= div_ratio_i;
            r_pend <= 1'b0;
         end else if (r_pend) begin
            r_init <= r_pend_val;
            r_pend <= 1'b0;
         end

         if ((r_state == ST_IDLE) || (w_nxt == ST_IDLE) || (w_nxt == ST_SHIFT)) begin
            r_lock   <= '0;
            r_locked <= 1'b0;
         end else if ((r_state == ST_FILTER) || (r_state == ST_HOLDOFF)) begin
            r_lock   <= w_lock_inc;
            r_locked <= (w_lock_inc == '1);
         end
      end
   end

   assign positiveShift_o = r_pos;
   assign negativeShift_o = r_neg;
   assign initValue_o     = r_init;
   assign locked_o        = r_locked;
   assign busy_o          = r_busy;

endmodule

// File: tb/tb_dpll_shift_scheduler.sv
// Scoreboard bench for dpll_shift_scheduler: an edge-indexed rule model predicts
// shift pulses (queued) and the initValue/busy/locked outputs every cycle.
module tb_dpll_shift_scheduler;

   localparam int INIT_DIV = 50;
   localparam int LOCK_MAX = 255;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       enable_i = 1'b0;
   logic       lead_i = 1'b0;
   logic       lag_i = 1'b0;
   logic [3:0] filt_len_i = 4'd4;
   logic [3:0] holdoff_i = 4'd0;
   logic [7:0] div_ratio_i = 8'd0;
   logic       load_i = 1'b0;
   logic       positiveShift_o;
   logic       negativeShift_o;
   logic [7:0] initValue_o;
   logic       locked_o;
   logic       busy_o;

   dpll_shift_scheduler #(
      .WIDTH(8), .FILT_W(4), .HOLD_W(4), .LOCK_W(8), .INIT_DIV(INIT_DIV)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .lead_i(lead_i), .lag_i(lag_i), .filt_len_i(filt_len_i),
      .holdoff_i(holdoff_i), .div_ratio_i(div_ratio_i), .load_i(load_i),
      .positiveShift_o(positiveShift_o), .negativeShift_o(negativeShift_o),
      .initValue_o(initValue_o), .locked_o(locked_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at edge", nm, act, exp);
      end
   endtask

   typedef struct {int edge_no; bit dir;} exp_t;
   exp_t exp_q[$];

   // rule model: edges are numbered; after a trigger at edge t, edge t+1 is the
   // shift edge and events are ignored until edge t+2+holdoff
   int cyc = 0;
   bit m_act, m_dir, m_pend, m_busy_exp;
   int m_acc, m_busy_from, m_ready, m_lock, m_init, m_pval;

   always @(posedge clk_i or negedge reset_i) begin
      int n;
      bit lo, la, defer;
      if (!reset_i) begin
         m_act = 0; m_acc = 0; m_busy_from = -100; m_ready = -100;
         m_lock = 0; m_init = INIT_DIV; m_pend = 0; m_pval = 0; m_busy_exp = 0; m_dir = 0;
      end else begin
         cyc++;
         n  = (filt_len_i == 0) ? 1 : int'(filt_len_i);
         lo = lead_i && !lag_i;
         la = lag_i && !lead_i;
         defer = m_act && enable_i && (cyc >= m_busy_from) && (cyc < m_ready - 1);
         if (defer) begin
            if (load_i) begin m_pend = 1; m_pval = int'(div_ratio_i); end
         end else if (load_i) begin
            m_init = int'(div_ratio_i); m_pend = 0;
         end else if (m_pend) begin
            m_init = m_pval; m_pend = 0;
         end
         if (!enable_i) begin
            m_act = 0; m_acc = 0; m_lock = 0;
         end else if (!m_act) begin
            m_act = 1; m_acc = 0; m_lock = 0; m_ready = cyc + 1;
         end else if (cyc == m_busy_from) begin
            exp_q.push_back('{edge_no: cyc, dir: m_dir});
         end else if (cyc < m_ready) begin
            m_lock = (m_lock < LOCK_MAX) ? m_lock + 1 : LOCK_MAX;
         end else if ((lo && m_acc == n - 1) || (la && m_acc == -(n - 1))) begin
            m_dir = lo; m_acc = 0; m_lock = 0;
            m_busy_from = cyc + 1;
            m_ready = cyc + 2 + int'(holdoff_i);
         end else begin
            if (lo) m_acc++;
            else if (la) m_acc--;
            m_lock = (m_lock < LOCK_MAX) ? m_lock + 1 : LOCK_MAX;
         end
         m_busy_exp = m_act && (cyc + 1 >= m_busy_from) && (cyc + 1 < m_ready);
      end
   end

   int pos_cnt = 0;
   int neg_cnt = 0;
   int pulse_log[$];

   always @(negedge clk_i) begin
      exp_t e;
      if (reset_i) begin
         if (positiveShift_o || negativeShift_o) begin
            chk("shift_one_hot", {31'd0, positiveShift_o & negativeShift_o}, 0);
            if (positiveShift_o) pos_cnt++; else neg_cnt++;
            pulse_log.push_back(cyc);
            chk("shift_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("shift_edge", cyc, e.edge_no);
               chk("shift_dir", {31'd0, positiveShift_o}, {31'd0, e.dir});
            end
         end else begin
            chk("shift_missing", {31'd0, exp_q.size() > 0 && exp_q[0].edge_no <= cyc}, 0);
            if (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) void'(exp_q.pop_front());
         end
         chk("initValue", {24'd0, initValue_o}, m_init);
         chk("busy", {31'd0, busy_o}, {31'd0, m_busy_exp});
         chk("locked", {31'd0, locked_o}, {31'd0, m_lock == LOCK_MAX});
      end
   end

   task automatic step(input bit l, input bit g);
      @(negedge clk_i);
      lead_i = l; lag_i = g; load_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic ld(input logic [7:0] v);
      @(negedge clk_i);
      lead_i = 1'b0; lag_i = 1'b0; load_i = 1'b1; div_ratio_i = v;
   endtask

   task automatic wait_not_busy(input string nm);
      int i;
      for (i = 0; i < 40 && busy_o; i++) @(negedge clk_i);
      chk(nm, {31'd0, busy_o}, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, n0;
      exp_t e;
      repeat (3) @(negedge clk_i);
      chk("reset_init", {24'd0, initValue_o}, INIT_DIV);
      chk("reset_pos", {31'd0, positiveShift_o}, 0);
      chk("reset_neg", {31'd0, negativeShift_o}, 0);
      chk("reset_locked", {31'd0, locked_o}, 0);
      chk("reset_busy", {31'd0, busy_o}, 0);
      #2 reset_i = 1'b1;

      // four spaced leads at N=4 -> one positive shift
      @(negedge clk_i); enable_i = 1'b1;
      idle(2);
      p0 = pos_cnt; n0 = neg_cnt;
      repeat (4) begin step(1, 0); idle(2); end
      idle(3);
      chk("t1_pos", pos_cnt - p0, 1);
      chk("t1_neg", neg_cnt - n0, 0);

      // lead,lead then six lags -> one negative shift
      p0 = pos_cnt; n0 = neg_cnt;
      repeat (2) begin step(1, 0); idle(1); end
      repeat (6) begin step(0, 1); idle(1); end
      idle(3);
      chk("t2_pos", pos_cnt - p0, 0);
      chk("t2_neg", neg_cnt - n0, 1);

      // N=1, holdoff=5, lead held for 20 edges -> a pulse every 7 cycles
      pulse_log.delete();
      @(negedge clk_i);
      filt_len_i = 4'd1; holdoff_i = 4'd5; lead_i = 1'b1; lag_i = 1'b0;
      repeat (19) step(1, 0);
      idle(8);
      chk("t3_pulses", pulse_log.size(), 3);
      if (pulse_log.size() >= 3) begin
         chk("t3_period_a", pulse_log[1] - pulse_log[0], 7);
         chk("t3_period_b", pulse_log[2] - pulse_log[1], 7);
      end

      // simultaneous strobes never move the filter; lock after quiet time
      @(negedge clk_i);
      filt_len_i = 4'd2; holdoff_i = 4'd0; lead_i = 1'b1; lag_i = 1'b1;
      repeat (9) step(1, 1);
      idle(1);
      for (int i = 0; i < 300 && !locked_o; i++) @(negedge clk_i);
      chk("t4_locked", {31'd0, locked_o}, 1);
      p0 = pos_cnt;
      step(1, 0);
      step(1, 0);
      step(0, 0);
      chk("t4_lock_drop", {31'd0, locked_o}, 0);
      idle(3);
      chk("t4_pos", pos_cnt - p0, 1);

      // loads during HOLDOFF are held until HOLDOFF ends; last one wins
      @(negedge clk_i);
      filt_len_i = 4'd1; holdoff_i = 4'd6; lead_i = 1'b0; lag_i = 1'b0;
      step(1, 0);
      idle(2);
      ld(8'd37);
      idle(1);
      chk("t5_init_held", {24'd0, initValue_o}, INIT_DIV);
      wait_not_busy("t5_busy_end");
      chk("t5_init_37", {24'd0, initValue_o}, 37);
      step(1, 0);
      idle(2);
      ld(8'd40);
      idle(1);
      ld(8'd12);
      idle(1);
      chk("t5_init_held2", {24'd0, initValue_o}, 37);
      wait_not_busy("t5_busy_end2");
      chk("t5_init_12", {24'd0, initValue_o}, 12);

      // disable with acc=+2 restarts the filter from zero
      @(negedge clk_i);
      filt_len_i = 4'd4; holdoff_i = 4'd0; lead_i = 1'b0; lag_i = 1'b0;
      idle(2);
      p0 = pos_cnt;
      repeat (2) begin step(1, 0); idle(1); end
      @(negedge clk_i); enable_i = 1'b0;
      @(negedge clk_i); enable_i = 1'b1;
      idle(2);
      repeat (3) begin step(1, 0); idle(1); end
      idle(3);
      chk("t6_no_shift", pos_cnt - p0, 0);
      step(1, 0);
      idle(3);
      chk("t6_shift", pos_cnt - p0, 1);

      // reset while a shift pulse is high aborts it
      @(negedge clk_i); filt_len_i = 4'd1;
      p0 = pos_cnt;
      step(1, 0);
      step(0, 0);
      @(posedge clk_i);
      #1;
      chk("t7_pulse_pre", {31'd0, positiveShift_o}, 1);
      chk("t7_pulse_queued", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("t7_pulse_edge", cyc, e.edge_no);
      end
      reset_i = 1'b0;
      #1;
      chk("t7_pos_abort", {31'd0, positiveShift_o}, 0);
      chk("t7_init", {24'd0, initValue_o}, INIT_DIV);
      repeat (2) @(negedge clk_i);
      #2 reset_i = 1'b1;
      idle(6);
      chk("t7_no_pulse", pos_cnt - p0, 0);

      // randomized blocks, parameters changed only while disabled
      for (int blk = 0; blk < 8; blk++) begin
         @(negedge clk_i);
         enable_i = 1'b0; lead_i = 1'b0; lag_i = 1'b0; load_i = 1'b0;
         filt_len_i = 4'($urandom_range(0, 5));
         holdoff_i = 4'($urandom_range(0, 3));
         @(negedge clk_i); enable_i = 1'b1;
         for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            @(negedge clk_i);
            lead_i = (r < 3);
            lag_i = (r >= 2 && r < 5);
            load_i = ($urandom_range(0, 11) == 0);
            div_ratio_i = 8'($urandom_range(0, 255));
         end
      end
      idle(8);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpll_shift_scheduler.md
Name: dpll_shift_scheduler

Overview:
- Sequential loop filter and shift scheduler for the DPLL divider.
- Consumes lead/lag strobes from the phase detector and integrates them in a random-walk filter.
- Issues rate-limited single-cycle positive/negative shift commands to the divider, owns the divider's initial-value register and reports lock.
- Sits between the phase detector and the divider.

Parameters:
WIDTH, 8, divider counter width; width of initValue_o and div_ratio_i
FILT_W, 4, width of filter threshold input
HOLD_W, 4, width of holdoff input
LOCK_W, 8, width of lock-quiet counter
INIT_DIV, 50, reset value of initValue_o (must fit WIDTH)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
enable_i  in  1  loop enable; low forces IDLE
lead_i  in  1  phase-detector "reference leads" strobe, one cycle per event
lag_i  in  1  phase-detector "reference lags" strobe, one cycle per event
filt_len_i  in  FILT_W  filter threshold N; 0 treated as 1
holdoff_i  in  HOLD_W  cycles to ignore events after a shift
div_ratio_i  in  WIDTH  new divider initial value
load_i  in  1  one-cycle request to update initValue_o
positiveShift_o  out  1  one-cycle shift-advance command to divider
negativeShift_o  out  1  one-cycle shift-retard command to divider
initValue_o  out  WIDTH  divider initial value
locked_o  out  1  loop quiet for 2^LOCK_W-1 cycles
busy_o  out  1  high in SHIFT or HOLDOFF

Behaviour:
- Clock and reset: reset reset_i, asynchronous, active-low; clock clk_i. All state is on posedge clk_i.
- Reset values: state IDLE, signed accumulator acc=0, positiveShift_o=0, negativeShift_o=0, locked_o=0, busy_o=0, initValue_o=INIT_DIV, load pending flag=0, hold and lock counters 0.
- States IDLE, FILTER, SHIFT, HOLDOFF. Any state with enable_i=0 goes to IDLE next edge. On that transition acc, shift outputs and lock state clear.
- IDLE: if enable_i=1, go to FILTER next edge.
- FILTER accumulator:
  - lead_i&!lag_i: acc+1.
  - lag_i&!lead_i: acc-1.
  - Both or neither: hold.
  - acc is signed, FILT_W+1 bits, range -(N-1)..+(N-1).
- FILTER thresholds:
  - lead_i alone with acc==N-1: acc<=0, dir=+, go to SHIFT.
  - lag_i alone with acc==-(N-1): acc<=0, dir=-, go to SHIFT.
  - N=0 or 1: every single event triggers.
- SHIFT: lasts exactly one cycle. positiveShift_o (dir=+) or negativeShift_o (dir=-) is high for that cycle only. Both are never high together.
  - Next state is HOLDOFF with hold counter=holdoff_i if holdoff_i!=0, else FILTER.
  - Latency: the triggering event sampled at edge t gives a pulse visible from edge t+1 to t+2.
- HOLDOFF: decrement the hold counter each edge. Return to FILTER on the edge where the counter equals 1, i.e. exactly holdoff_i cycles in HOLDOFF. lead_i/lag_i are dropped in SHIFT and HOLDOFF and acc stays 0.
- Load:
  - load_i in IDLE or FILTER: initValue_o<=div_ratio_i next edge.
  - load_i in SHIFT or HOLDOFF: latch div_ratio_i and set pending.
  - Apply the pending value on the first edge in FILTER or IDLE. A later load overwrites a pending one.
  - Reset clears pending; disable does not.
- Lock:
  - The lock counter increments each edge in FILTER/HOLDOFF and saturates at all-ones.
  - It clears on entry to SHIFT and in IDLE.
  - locked_o is a registered (counter==all-ones) flag and drops in the same edge that enters SHIFT.
- busy_o is registered and tracks the next state (SHIFT or HOLDOFF).
- Reset mid-operation: an in-flight shift pulse is aborted immediately (asynchronous clear). No pulse is emitted after reset release until a new threshold crossing.

Test Plan:
- Reset release, enable_i=1, N=4, 4 lead_i strobes spaced 3 cycles apart -> exactly one positiveShift_o pulse, 1 cycle wide, 1 edge after the 4th strobe; negativeShift_o stays 0.
- N=4, sequence lead,lead,lag,lag,lag,lag,lag,lag -> acc goes +2 then down to -3; the 7th event reaches -(N-1)=-3 and the 8th lag triggers one negativeShift_o; no positive pulse.
- N=1, holdoff_i=5, lead_i held high 20 cycles -> positiveShift_o pulses every 7 cycles (1 FILTER + 1 SHIFT + 5 HOLDOFF); busy_o high 6 of each 7 cycles.
- Simultaneous lead_i&lag_i for 10 cycles, N=2 -> no shift; after LOCK_W=8 gives 255 quiet cycles, locked_o=1. A subsequent trigger drops locked_o on the shift edge.
- load_i with div_ratio_i=8'd37 during HOLDOFF -> initValue_o stays 50 until the HOLDOFF->FILTER edge, then 37. A second load of 8'd12 during the same HOLDOFF gives final 12.
- Assert reset_i=0 mid-SHIFT -> shift output falls asynchronously, initValue_o=50. enable_i dropped in FILTER with acc=+2 -> IDLE, and re-enable restarts from acc=0.
